// File: rtl/led_pattern_sequencer.sv
// Mode sequencer for an LED pattern engine. It synchronizes and debounces the
// mode controls, then drives mode, seed, a load pulse and the step tick.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned DWELL    = 64,
  parameter int unsigned DEB_LEN  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        auto_en,
  input  logic        btn_next,
  output logic        tick,
  output logic [3:0]  mode,
  output logic        mode_load,
  output logic [15:0] seed
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DWELL + 1);
  localparam int unsigned BW = $clog2(DEB_LEN + 1);

  typedef enum logic [1:0] {MANUAL, AUTO, LOAD} state_t;

  function automatic logic [3:0] code_of(input logic [2:0] i);
    case (i)
      3'd0:    code_of = 4'b0000;
      3'd1:    code_of = 4'b1000;
      3'd2:    code_of = 4'b0100;
      3'd3:    code_of = 4'b0010;
      3'd4:    code_of = 4'b0001;
      3'd5:    code_of = 4'b1100;
      3'd6:    code_of = 4'b1010;
      default: code_of = 4'b1001;
    endcase
  endfunction

  function automatic logic [15:0] seed_of(input logic [2:0] i);
    case (i)
      3'd0:    seed_of = 16'h0001;
      3'd1:    seed_of = 16'hAAAA;
      3'd2:    seed_of = 16'h0001;
      3'd3:    seed_of = 16'h00FF;
      3'd4:    seed_of = 16'h8001;
      3'd5:    seed_of = 16'h0180;
      3'd6:    seed_of = 16'h0180;
      default: seed_of = 16'h8001;
    endcase
  endfunction

  logic [3:0]    sw_s1, sw_s2, sw_prev, sw_db;
  logic          ae_s1, ae_s2, bn_s1, bn_s2, bn_prev;
  logic [BW-1:0] run, run_c;
  logic          db_legal;
  logic [2:0]    db_idx;

  state_t        state, state_n;
  logic          load_pend, load_c, tick_n;
  logic [2:0]    idx, nidx;
  logic [DW-1:0] dwell, dwell_n;
  logic [TW-1:0] cnt, cnt_n;

  // Run length of the current synchronized switch code, saturating at DEB_LEN
  assign run_c = (sw_s2 != sw_prev) ? BW'(1) :
                 (run == BW'(DEB_LEN)) ? run : run + BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_prev <= '0;
      sw_db   <= '0;
      run     <= '0;
      ae_s1   <= 1'b0;
      ae_s2   <= 1'b0;
      bn_s1   <= 1'b0;
      bn_s2   <= 1'b0;
      bn_prev <= 1'b0;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
      run     <= run_c;
      if (run_c >= BW'(DEB_LEN)) sw_db <= sw_s2;
      ae_s1   <= auto_en;
      ae_s2   <= ae_s1;
      bn_s1   <= btn_next;
      bn_s2   <= bn_s1;
      bn_prev <= bn_s2;
    end
  end

  always_comb begin
    db_legal = 1'b1;
    db_idx   = 3'd0;
    case (sw_db)
      4'b0000: db_idx = 3'd0;
      4'b1000: db_idx = 3'd1;
      4'b0100: db_idx = 3'd2;
      4'b0010: db_idx = 3'd3;
      4'b0001: db_idx = 3'd4;
      4'b1100: db_idx = 3'd5;
      4'b1010: db_idx = 3'd6;
      4'b1001: db_idx = 3'd7;
      default: db_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MANUAL;
    else     state <= state_n;
  end

  // Next state; load_c marks the edge that enters LOAD with index nidx
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    nidx    = idx;
    dwell_n = dwell;
    case (state)
      MANUAL: begin
        dwell_n = '0;
        if (load_pend) begin
          load_c = 1'b1;
          nidx   = 3'd0;
        end else if (ae_s2) begin
          state_n = AUTO;
        end else if (db_legal && (sw_db != mode)) begin
          load_c = 1'b1;
          nidx   = db_idx;
        end
      end
      AUTO: begin
        if (!ae_s2) begin
          state_n = MANUAL;
          dwell_n = '0;
        end else begin
          if (tick) dwell_n = dwell + DW'(1);
          if ((tick && (dwell_n == DW'(DWELL))) || (bn_s2 && !bn_prev)) begin
            load_c = 1'b1;
            nidx   = idx + 3'd1;
          end
        end
      end
      LOAD: begin
        dwell_n = '0;
        state_n = ae_s2 ? AUTO : MANUAL;
      end
      default: state_n = MANUAL;
    endcase
    if (load_c) begin
      state_n = LOAD;
      dwell_n = '0;
    end
  end

  // Tick counter is held at zero on entry to and exit from LOAD
  assign cnt_n  = (load_c || (state == LOAD) || (cnt == TW'(TICK_DIV - 1))) ? '0 : cnt + TW'(1);
  assign tick_n = !load_c && (cnt_n == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_pend <= 1'b1;
      idx       <= '0;
      dwell     <= '0;
      cnt       <= '0;
      tick      <= 1'b0;
      mode_load <= 1'b0;
      mode      <= 4'b0000;
      seed      <= 16'h0001;
    end else begin
      load_pend <= 1'b0;
      idx       <= nidx;
      dwell     <= dwell_n;
      cnt       <= cnt_n;
      tick      <= tick_n;
      mode_load <= load_c;
      if (load_c) begin
        mode <= code_of(nidx);
        seed <= seed_of(nidx);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed table rows and corner sequences,
// then randomized controls checked cycle by cycle against a reference model.
module tb_led_pattern_sequencer;
  localparam int TD  = 4;
  localparam int DWL = 3;
  localparam int DEB = 4;
  localparam logic [3:0]  CODES [8] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'hA, 4'h9};
  localparam logic [15:0] SEEDS [8] = '{16'h0001, 16'hAAAA, 16'h0001, 16'h00FF,
                                        16'h8001, 16'h0180, 16'h0180, 16'h8001};

  logic clk = 1'b0;
  logic rst;
  logic [3:0] sw;
  logic auto_en, btn_next;
  logic tick, mode_load;
  logic [3:0] mode;
  logic [15:0] seed;

  int n_vec = 0;
  int n_err = 0;
  int loads;

  led_pattern_sequencer #(.TICK_DIV(TD), .DWELL(DWL), .DEB_LEN(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .auto_en(auto_en), .btn_next(btn_next),
    .tick(tick), .mode(mode), .mode_load(mode_load), .seed(seed)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (mode_load) loads++;
    chk("tick_load_excl", {31'd0, tick & mode_load}, 32'd0);
  endtask

  // Expects rst released just after an edge
  task automatic check_boot();
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      chk("boot_load", {31'd0, mode_load}, {31'd0, c == 1});
      chk("boot_tick", {31'd0, tick}, {31'd0, (c >= 2) && ((c - 1) % TD == 0)});
      if (c == 1) begin
        chk("boot_mode", {28'd0, mode}, 32'h0);
        chk("boot_seed", {16'd0, seed}, 32'h0001);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic        ae;
    logic        btn;
    int          cycles;
    logic        until_load;
    int          exp_loads;
    int          exp_cyc;
    logic [3:0]  exp_mode;
    logic [15:0] exp_seed;
  } vec_t;

  vec_t tbl [11];

  // Reference model state
  logic [3:0] m_sw1, m_sw2, m_db;
  logic       m_ae1, m_ae2, m_bn1, m_bn2, m_bnp;
  logic [3:0] hist [$];
  int         m_state;   // 0 manual, 1 auto, 2 load
  bit         m_pend, m_load;
  int         m_idx, m_dwell, m_k;

  function automatic bit is_legal(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (CODES[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int index_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (CODES[i] == c) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_db = '0;
    m_ae1 = 0; m_ae2 = 0; m_bn1 = 0; m_bn2 = 0; m_bnp = 0;
    hist.delete();
    m_state = 0; m_pend = 1; m_load = 0;
    m_idx = 0; m_dwell = 0; m_k = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic a, input logic b);
    bit tick_now, ld, same;
    int nidx;
    tick_now = (m_k > 0) && (m_k % TD == 0);
    ld = 0;
    nidx = m_idx;
    case (m_state)
      0: begin
        if (m_pend) begin ld = 1; nidx = 0; end
        else if (m_ae2) begin m_state = 1; m_dwell = 0; end
        else if (is_legal(m_db) && m_db != CODES[m_idx]) begin ld = 1; nidx = index_of(m_db); end
      end
      1: begin
        if (!m_ae2) m_state = 0;
        else begin
          if (tick_now) m_dwell++;
          if ((tick_now && m_dwell == DWL) || (m_bn2 && !m_bnp)) begin
            ld = 1;
            nidx = (m_idx + 1) % 8;
          end
        end
      end
      default: m_state = m_ae2 ? 1 : 0;
    endcase
    m_pend = 0;
    if (ld) begin m_state = 2; m_idx = nidx; m_dwell = 0; m_k = 0; end
    else m_k++;
    m_load = ld;
    // Debounce: accept once the last DEB synchronized samples agree
    hist.push_front(m_sw2);
    if (hist.size() > DEB) void'(hist.pop_back());
    if (hist.size() == DEB) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
      if (same) m_db = hist[0];
    end
    m_bnp = m_bn2; m_bn2 = m_bn1; m_bn1 = b;
    m_ae2 = m_ae1; m_ae1 = a;
    m_sw2 = m_sw1; m_sw1 = s;
  endtask

  initial begin
    int n, hold;
    logic e_tick;
    tbl[0]  = '{4'h8, 0, 0, 14, 0, 1, 0,  4'h8, 16'hAAAA};
    tbl[1]  = '{4'h7, 0, 0, 14, 0, 0, 0,  4'h8, 16'hAAAA};
    tbl[2]  = '{4'h4, 0, 0, 2,  0, 0, 0,  4'h8, 16'hAAAA};
    tbl[3]  = '{4'h7, 0, 0, 10, 0, 0, 0,  4'h8, 16'hAAAA};
    tbl[4]  = '{4'h2, 0, 0, 14, 0, 1, 0,  4'h2, 16'h00FF};
    tbl[5]  = '{4'h2, 1, 0, 6,  0, 0, 0,  4'h2, 16'h00FF};
    tbl[6]  = '{4'h2, 1, 0, 0,  1, 1, 0,  4'h1, 16'h8001};
    tbl[7]  = '{4'h2, 1, 0, 0,  1, 1, 13, 4'hC, 16'h0180};
    tbl[8]  = '{4'h2, 1, 0, 0,  1, 1, 13, 4'hA, 16'h0180};
    tbl[9]  = '{4'h2, 1, 0, 0,  1, 1, 13, 4'h9, 16'h8001};
    tbl[10] = '{4'h2, 1, 0, 0,  1, 1, 13, 4'h0, 16'h0001};

    rst = 1; sw = 0; auto_en = 0; btn_next = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", {28'd0, mode}, 32'h0);
    chk("rst_seed", {16'd0, seed}, 32'h0001);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_load", {31'd0, mode_load}, 32'd0);
    rst = 0;
    check_boot();

    foreach (tbl[i]) begin
      sw = tbl[i].sw; auto_en = tbl[i].ae; btn_next = tbl[i].btn;
      loads = 0;
      n = 0;
      if (tbl[i].until_load) begin
        while (loads < tbl[i].exp_loads && n < 300) begin step(); n++; end
        if (tbl[i].exp_cyc != 0) chk($sformatf("row%0d_cycles", i), n, tbl[i].exp_cyc);
      end else begin
        repeat (tbl[i].cycles) step();
      end
      chk($sformatf("row%0d_loads", i), loads, tbl[i].exp_loads);
      chk($sformatf("row%0d_mode", i), {28'd0, mode}, {28'd0, tbl[i].exp_mode});
      chk($sformatf("row%0d_seed", i), {16'd0, seed}, {16'd0, tbl[i].exp_seed});
    end

    // Button edge coinciding with the third dwell tick: one advance only
    repeat (10) step();
    btn_next = 1;
    step();
    chk("coin_pre_tick", {31'd0, tick}, 32'd0);
    step();
    chk("coin_tick", {31'd0, tick}, 32'd1);
    step();
    chk("coin_load", {31'd0, mode_load}, 32'd1);
    chk("coin_mode", {28'd0, mode}, 32'h8);
    chk("coin_seed", {16'd0, seed}, 32'hAAAA);
    loads = 0;
    repeat (12) step();
    chk("coin_no_extra", loads, 0);
    step();
    chk("coin_next_load", {31'd0, mode_load}, 32'd1);
    chk("coin_next_mode", {28'd0, mode}, 32'h4);

    // Reset asserted during a LOAD cycle
    rst = 1; sw = 0; auto_en = 0; btn_next = 0;
    #1;
    chk("rl_mode", {28'd0, mode}, 32'h0);
    chk("rl_seed", {16'd0, seed}, 32'h0001);
    chk("rl_load", {31'd0, mode_load}, 32'd0);
    chk("rl_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rl_hold_load", {31'd0, mode_load}, 32'd0);
    rst = 0;
    check_boot();

    // Randomized controls against the reference model
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sw = ($urandom_range(0, 3) != 0) ? CODES[$urandom_range(0, 7)] : 4'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 79) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
      @(posedge clk);
      model_step(sw, auto_en, btn_next);
      #1;
      e_tick = !m_load && (m_k > 0) && (m_k % TD == 0);
      chk("rnd_out", {10'd0, tick, mode_load, mode, seed},
          {10'd0, e_tick, m_load, CODES[m_idx], SEEDS[m_idx]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clk cycles per pattern step.
REQ-002 Parameter DWELL, default 64, pattern steps per mode in auto mode.
REQ-003 Parameter DEB_LEN, default 65536, clk cycles a switch code must stay stable to be accepted.
REQ-004 clk  in  1  single system clock, all flops rise-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sw  in  4  manual mode request code, asynchronous to clk.
REQ-007 auto_en  in  1  1 = auto-cycle modes, 0 = manual; asynchronous.
REQ-008 btn_next  in  1  auto-mode advance request, level input, asynchronous.
REQ-009 tick  out  1  one-cycle step enable to the pattern engine.
REQ-010 mode  out  4  active pattern code to the pattern engine.
REQ-011 mode_load  out  1  one-cycle pulse: engine loads seed, mode is new.
REQ-012 seed  out  16  initial LED word for the current mode.

Function
REQ-013 sw, auto_en and btn_next SHALL each pass a 2-flop synchronizer before use.
REQ-014 sw_db SHALL update to the synchronized sw only after that value has been unchanged for DEB_LEN consecutive cycles.
REQ-015 Legal codes, index 0..7: 0000, 1000, 0100, 0010, 0001, 1100, 1010, 1001; all other codes are illegal.
REQ-016 Seed table in index order: 0001, AAAA, 0001, 00FF, 8001, 0180, 0180, 8001 (hex).
REQ-017 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 exactly in the cycle the count equals TICK_DIV-1.
REQ-018 The FSM SHALL have the states MANUAL, AUTO and LOAD; LOAD lasts exactly one cycle.
REQ-019 In LOAD: mode and seed SHALL take the new index's values, mode_load=1, tick=0, tick counter and dwell counter cleared; next state is AUTO if the synchronized auto_en=1, else MANUAL.
REQ-020 MANUAL: a legal sw_db different from mode SHALL cause a transition to LOAD with that code; an illegal or equal sw_db SHALL hold mode.
REQ-021 MANUAL: btn_next SHALL be ignored.
REQ-022 MANUAL with synchronized auto_en=1 SHALL go to AUTO with the index of the current mode and dwell counter 0, and SHALL NOT emit mode_load.
REQ-023 AUTO: the dwell counter SHALL increment on each tick; at DWELL ticks the FSM SHALL go to LOAD with index+1, wrapping 7->0.
REQ-024 AUTO: a rising edge of synchronized btn_next SHALL go to LOAD with index+1.
REQ-025 Dwell expiry and btn_next edge in the same cycle SHALL cause exactly one advance.
REQ-026 AUTO with synchronized auto_en=0 SHALL go to MANUAL and apply REQ-020 in the next cycle.
REQ-027 mode and seed SHALL change only in a LOAD cycle.
REQ-028 mode_load and tick SHALL never be 1 in the same cycle.

Reset
REQ-029 While rst=1: mode=0000, seed=0001, tick=0, mode_load=0, all counters 0, index 0, synchronizers 0, sw_db=0000.
REQ-030 The first cycle after rst falls SHALL be LOAD, giving one mode_load pulse with mode=0000 and seed=0001.
REQ-031 rst asserted mid-operation, including in LOAD, SHALL force the REQ-029 values immediately, with no pending advance retained.

Verification (TICK_DIV=4, DWELL=3, DEB_LEN=4)
REQ-032 Release rst -> one mode_load with mode=0000 and seed=0001; tick then every 4th cycle, first tick 4 cycles after the LOAD.
REQ-033 Manual mode, sw=1000 held -> after sync plus debounce, one mode_load with mode=1000 and seed=AAAA; sw=0111 -> mode unchanged, no mode_load.
REQ-034 Manual mode, sw glitches to 0100 for 2 cycles -> no mode change.
REQ-035 auto_en=1 at mode 0010 -> no load; after 3 ticks mode=0001, seed=8001; continue through 1001 -> next mode 0000 (wrap).
REQ-036 Auto mode, btn_next rises in the same cycle as the third tick -> single advance only.
REQ-037 Assert rst during a LOAD cycle -> outputs return to the reset values immediately; after release, behaviour matches REQ-032.
